// File: rtl/bus_master_pkg.sv
// Shared types and encodings for the bus initiator and its lane-steering helper.
package bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUS_RD,
    RD_DATA,
    BUS_WR,
    RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  // Size 3 is not a legal access and is treated like a misaligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bus_lane_steer.sv
// Combinational byte-lane steering: store-data replication, byteenable, and load extraction.
module bus_lane_steer
  import bus_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  input  logic        is_signed,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = readdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? readdata[31:16] : readdata[15:0];

  always_comb begin
    byteenable = 4'b0000;
    writedata  = wdata;
    rdata      = 32'h0;
    case (size)
      SZ_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        rdata      = {{24{is_signed & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        rdata      = {{16{is_signed & lane_h[15]}}, lane_h};
      end
      SZ_WORD: begin
        byteenable = 4'b1111;
        rdata      = readdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_master_if.sv
// Avalon-style bus initiator arbitrating fetch and data requests from the core.
// Optional BUS_TIMEOUT_EN aborts a bus cycle stalled for TIMEOUT_CYCLES.
module bus_master_if
  import bus_master_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
`ifdef BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_addr,
  output logic        ireq_ready,
  input  logic        dreq_valid,
  input  logic        dreq_write,
  input  logic [1:0]  dreq_size,
  input  logic        dreq_signed,
  input  logic [31:0] dreq_addr,
  input  logic [31:0] dreq_wdata,
  output logic        dreq_ready,
  output logic        resp_valid,
  output logic        resp_is_data,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] last_addr
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, last_addr_q;
  logic [1:0]  size_q;
  logic        signed_q, is_data_q, err_q;

  logic        accept_d, accept_i, accept, req_bad, req_write, req_signed, tmo_hit;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  steer_be;
  logic [31:0] steer_wd, steer_rdata;

  // Data port wins arbitration; nothing is accepted while reset is held.
  assign accept_d = reset && (state_q == IDLE) && dreq_valid;
  assign accept_i = reset && (state_q == IDLE) && !dreq_valid && ireq_valid;
  assign accept   = accept_d | accept_i;

  assign req_addr   = accept_d ? dreq_addr : ireq_addr;
  assign req_size   = accept_d ? dreq_size : SZ_WORD;
  assign req_write  = accept_d & dreq_write;
  assign req_signed = accept_d & dreq_signed;
  assign req_bad    = misaligned(req_size, req_addr[1:0]);

`ifdef BUS_TIMEOUT_EN
  logic [31:0] tmo_q;

  assign tmo_hit = waitrequest && (tmo_q == TIMEOUT_CYCLES - 1);

  // Cleared while idle so every bus cycle starts counting from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_q <= 32'd0;
    end else if (state_q == IDLE) begin
      tmo_q <= 32'd0;
    end else if ((state_q == BUS_RD || state_q == BUS_WR) && waitrequest) begin
      tmo_q <= tmo_q + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad)        state_d = RESP;
          else if (req_write) state_d = BUS_WR;
          else                state_d = BUS_RD;
        end
      end
      BUS_RD: begin
        if (!waitrequest)  state_d = RD_DATA;
        else if (tmo_hit)  state_d = RESP;
      end
      RD_DATA: state_d = RESP;
      BUS_WR: begin
        if (!waitrequest || tmo_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      wdata_q     <= 32'h0;
      is_data_q   <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      last_addr_q <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q      <= req_addr;
        size_q      <= req_size;
        signed_q    <= req_signed;
        wdata_q     <= dreq_wdata;
        is_data_q   <= accept_d;
        err_q       <= req_bad;
        rdata_q     <= 32'h0;
        last_addr_q <= req_addr;
      end
      if (state_q == RD_DATA) rdata_q <= steer_rdata;
      if (tmo_hit && (state_q == BUS_RD || state_q == BUS_WR)) err_q <= 1'b1;
    end
  end

  bus_lane_steer u_steer (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .readdata   (readdata),
    .is_signed  (signed_q),
    .byteenable (steer_be),
    .writedata  (steer_wd),
    .rdata      (steer_rdata)
  );

  assign read         = (state_q == BUS_RD);
  assign write        = (state_q == BUS_WR);
  assign address      = {addr_q[31:2], 2'b00};
  assign byteenable   = (read | write) ? steer_be : 4'b0000;
  assign writedata    = write ? steer_wd : 32'h0;
  assign resp_valid   = (state_q == RESP);
  assign resp_err     = resp_valid & err_q;
  assign resp_is_data = is_data_q;
  assign resp_rdata   = rdata_q;
  assign ireq_ready   = accept_i;
  assign dreq_ready   = accept_d;
  assign last_addr    = last_addr_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed self-checking bench for bus_master_if.
module tb_bus_master_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        dreq_valid, dreq_write, dreq_signed;
  logic [1:0]  dreq_size;
  logic [31:0] dreq_addr, dreq_wdata;
  logic        dreq_ready;
  logic        resp_valid, resp_is_data, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata, last_addr;
  logic [3:0]  byteenable;
  logic        write, read, waitrequest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_master_if dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .ireq_ready   (ireq_ready),
    .dreq_valid   (dreq_valid),
    .dreq_write   (dreq_write),
    .dreq_size    (dreq_size),
    .dreq_signed  (dreq_signed),
    .dreq_addr    (dreq_addr),
    .dreq_wdata   (dreq_wdata),
    .dreq_ready   (dreq_ready),
    .resp_valid   (resp_valid),
    .resp_is_data (resp_is_data),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .address      (address),
    .byteenable   (byteenable),
    .writedata    (writedata),
    .write        (write),
    .read         (read),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .last_addr    (last_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dload(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
    dreq_valid  = 1'b1;
    dreq_write  = 1'b0;
    dreq_addr   = a;
    dreq_size   = sz;
    dreq_signed = sgn;
  endtask

  initial begin
    reset = 1'b0;
    ireq_valid = 1'b0; ireq_addr = 32'h0;
    dreq_valid = 1'b0; dreq_write = 1'b0; dreq_size = 2'd0; dreq_signed = 1'b0;
    dreq_addr = 32'h0; dreq_wdata = 32'h0;
    waitrequest = 1'b0; readdata = 32'h0;

    tick(); tick(); settle();
    check("rst_read", {31'h0, read}, 32'h0);
    check("rst_write", {31'h0, write}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_be", {28'h0, byteenable}, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_wdata", writedata, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_last_addr", last_addr, 32'hBFC0_0000);
    reset = 1'b1;

    // Fetch at reset vector, zero wait: response three cycles after accept.
    tick();
    ireq_valid = 1'b1; ireq_addr = 32'hBFC0_0000; readdata = 32'h3C08_1234;
    settle();
    check("f_ireq_ready", {31'h0, ireq_ready}, 32'h1);
    check("f_dreq_ready", {31'h0, dreq_ready}, 32'h0);
    tick(); ireq_valid = 1'b0; settle();
    check("f_read", {31'h0, read}, 32'h1);
    check("f_be", {28'h0, byteenable}, 32'hF);
    check("f_address", address, 32'hBFC0_0000);
    tick(); settle();
    check("f_read_drop", {31'h0, read}, 32'h0);
    check("f_no_early_resp", {31'h0, resp_valid}, 32'h0);
    tick(); settle();
    check("f_resp_valid", {31'h0, resp_valid}, 32'h1);
    check("f_rdata", resp_rdata, 32'h3C08_1234);
    check("f_is_data", {31'h0, resp_is_data}, 32'h0);
    check("f_err", {31'h0, resp_err}, 32'h0);
    tick(); settle();
    check("f_resp_pulse", {31'h0, resp_valid}, 32'h0);

    // Signed then unsigned byte load from lane 3.
    for (int s = 1; s >= 0; s--) begin
      dload(32'h0000_0103, 2'd0, s[0]); readdata = 32'h80FF_FFFF;
      settle();
      check("lb_dreq_ready", {31'h0, dreq_ready}, 32'h1);
      tick(); dreq_valid = 1'b0; settle();
      check("lb_be", {28'h0, byteenable}, 32'h8);
      check("lb_address", address, 32'h0000_0100);
      check("lb_last_addr", last_addr, 32'h0000_0103);
      tick(); tick(); settle();
      check("lb_resp_valid", {31'h0, resp_valid}, 32'h1);
      check("lb_rdata", resp_rdata, (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080);
      check("lb_is_data", {31'h0, resp_is_data}, 32'h1);
      tick();
    end

    // Half store with three stalled cycles: write held four cycles.
    dreq_valid = 1'b1; dreq_write = 1'b1; dreq_size = 2'd1; dreq_signed = 1'b0;
    dreq_addr = 32'h0000_0102; dreq_wdata = 32'h0000_BEEF; waitrequest = 1'b1;
    tick(); dreq_valid = 1'b0; dreq_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) waitrequest = 1'b0;
      settle();
      check("sh_write", {31'h0, write}, 32'h1);
      check("sh_read", {31'h0, read}, 32'h0);
      check("sh_be", {28'h0, byteenable}, 32'hC);
      check("sh_wdata", writedata, 32'hBEEF_BEEF);
      check("sh_address", address, 32'h0000_0100);
      tick();
    end
    settle();
    check("sh_write_drop", {31'h0, write}, 32'h0);
    check("sh_resp_valid", {31'h0, resp_valid}, 32'h1);
    check("sh_err", {31'h0, resp_err}, 32'h0);
    tick();

    // Simultaneous requests: data first, fetch in the following IDLE.
    ireq_valid = 1'b1; ireq_addr = 32'h0000_0200;
    dload(32'h0000_0300, 2'd2, 1'b0); readdata = 32'h1122_3344;
    settle();
    check("arb_dreq_ready", {31'h0, dreq_ready}, 32'h1);
    check("arb_ireq_ready", {31'h0, ireq_ready}, 32'h0);
    tick(); dreq_valid = 1'b0; settle();
    check("arb_busy_ready", {31'h0, ireq_ready}, 32'h0);
    tick(); tick(); settle();
    check("arb_d_resp", {31'h0, resp_valid}, 32'h1);
    check("arb_d_rdata", resp_rdata, 32'h1122_3344);
    check("arb_d_is_data", {31'h0, resp_is_data}, 32'h1);
    check("arb_resp_ready", {31'h0, ireq_ready}, 32'h0);
    tick(); readdata = 32'hCAFE_F00D; settle();
    check("arb_i_ready", {31'h0, ireq_ready}, 32'h1);
    tick(); ireq_valid = 1'b0; settle();
    check("arb_i_address", address, 32'h0000_0200);
    check("arb_i_last_addr", last_addr, 32'h0000_0200);
    tick(); tick(); settle();
    check("arb_i_resp", {31'h0, resp_valid}, 32'h1);
    check("arb_i_rdata", resp_rdata, 32'hCAFE_F00D);
    check("arb_i_is_data", {31'h0, resp_is_data}, 32'h0);
    tick();

    // Misaligned word load and illegal size: immediate error, no strobe.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) dload(32'h0000_0102, 2'd2, 1'b0);
      else        dload(32'h0000_0100, 2'd3, 1'b0);
      settle();
      check("mis_dreq_ready", {31'h0, dreq_ready}, 32'h1);
      tick(); dreq_valid = 1'b0; settle();
      check("mis_read", {31'h0, read}, 32'h0);
      check("mis_resp_valid", {31'h0, resp_valid}, 32'h1);
      check("mis_err", {31'h0, resp_err}, 32'h1);
      check("mis_rdata", resp_rdata, 32'h0);
      tick(); settle();
      check("mis_resp_pulse", {31'h0, resp_valid}, 32'h0);
    end

    // Reset during a stalled read drops the strobe without a response.
    dload(32'h0000_0400, 2'd2, 1'b0); waitrequest = 1'b1;
    tick(); dreq_valid = 1'b0; settle();
    check("rs_read", {31'h0, read}, 32'h1);
    tick(); reset = 1'b0;
    tick(); settle();
    check("rs_read_drop", {31'h0, read}, 32'h0);
    check("rs_no_resp", {31'h0, resp_valid}, 32'h0);
    check("rs_last_addr", last_addr, 32'hBFC0_0000);
    reset = 1'b1; waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("rs_quiet", {30'h0, resp_valid, read}, 32'h0);
    end

`ifdef BUS_TIMEOUT_EN
    begin
      int rd_cycles = 0;
      int waited = 0;
      dload(32'h0000_0500, 2'd2, 1'b0); waitrequest = 1'b1;
      tick(); dreq_valid = 1'b0; settle();
      while (!resp_valid && waited < 200) begin
        if (read) rd_cycles++;
        tick(); settle();
        waited++;
      end
      check("to_resp_seen", {31'h0, resp_valid}, 32'h1);
      check("to_err", {31'h0, resp_err}, 32'h1);
      check("to_rdata", resp_rdata, 32'h0);
      check("to_read_cycles", rd_cycles, 32'd64);
      waitrequest = 1'b0;
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
